// File: rtl/sha3_pad_unit_if.sv
// ============================================================================
// Module      : sha3_pad_unit_if
// Description : Streaming message-in / padded-lane-out bus for the SHA-3 pad unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sha3_pad_unit_if;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic [3:0]  s_nbytes;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [4:0]  m_lane_idx;
  logic        m_block_last;
  logic        m_msg_last;

  modport master (
    output s_valid, s_data, s_nbytes, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_lane_idx, m_block_last, m_msg_last
  );

  modport slave (
    input  s_valid, s_data, s_nbytes, s_last, m_ready,
    output s_ready, m_valid, m_data, m_lane_idx, m_block_last, m_msg_last
  );
endinterface

`default_nettype wire

// File: rtl/sha3_pad_unit.sv
// ============================================================================
// Module      : sha3_pad_unit
// Description : Splits a byte message into 64-bit rate lanes with SHA-3/SHAKE pad10*1.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sha3_pad_unit #(
  parameter int CNT_W    = 16,
  parameter bit SHAKE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cmode,
  sha3_pad_unit_if.slave   bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABSORB = 3'd1,
    PAD    = 3'd2,
    ZFILL  = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state;
  logic [4:0]  rate_m1;
  logic [4:0]  lane_cnt;
  logic        shake;

  logic        m_valid;
  logic [63:0] m_data;
  logic [4:0]  m_lane_idx;
  logic        m_block_last;
  logic        m_msg_last;

  logic        out_free;
  logic        s_ready;
  logic        at_end;
  logic [7:0]  suffix;
  logic [3:0]  nb_eff;
  logic [63:0] tail_lane;
  logic        mode_ok;
  logic [4:0]  mode_rate_m1;
  logic        xfer;

  assign out_free = !m_valid || bus.m_ready;
  assign s_ready  = (state == ABSORB) && out_free;
  assign xfer     = m_valid && bus.m_ready;
  assign at_end   = (lane_cnt == rate_m1);
  assign suffix   = shake ? 8'h1F : 8'h06;
  assign nb_eff   = (!bus.s_last || bus.s_nbytes > 4'd8) ? 4'd8 : bus.s_nbytes;

  assign bus.s_ready      = s_ready;
  assign bus.m_valid      = m_valid;
  assign bus.m_data       = m_data;
  assign bus.m_lane_idx   = m_lane_idx;
  assign bus.m_block_last = m_block_last;
  assign bus.m_msg_last   = m_msg_last;

  always_comb begin
    mode_ok      = 1'b1;
    mode_rate_m1 = 5'd0;
    case (cmode)
      3'd0:    mode_rate_m1 = 5'd17;
      3'd1:    mode_rate_m1 = 5'd16;
      3'd2:    mode_rate_m1 = 5'd12;
      3'd3:    mode_rate_m1 = 5'd8;
      3'd4: begin
        mode_rate_m1 = 5'd20;
        mode_ok      = SHAKE_EN;
      end
      3'd5: begin
        mode_rate_m1 = 5'd16;
        mode_ok      = SHAKE_EN;
      end
      default: mode_ok = 1'b0;
    endcase
  end

  // Short final lane: keep the valid bytes, drop the suffix right after them,
  // and close the block here too if this lane is the last one of the rate.
  always_comb begin
    tail_lane = 64'h0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nb_eff) begin
        tail_lane[8*i +: 8] = bus.s_data[8*i +: 8];
      end else if (4'(i) == nb_eff) begin
        tail_lane[8*i +: 8] = suffix;
      end
    end
    if (at_end) begin
      tail_lane[63] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rate_m1      <= 5'd0;
      lane_cnt     <= 5'd0;
      shake        <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= 64'h0;
      m_lane_idx   <= 5'd0;
      m_block_last <= 1'b0;
      m_msg_last   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      blk_cnt      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (xfer) begin
        m_valid <= 1'b0;
        if (m_block_last && blk_cnt != {CNT_W{1'b1}}) begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (mode_ok) begin
              state    <= ABSORB;
              rate_m1  <= mode_rate_m1;
              shake    <= cmode[2];
              lane_cnt <= 5'd0;
              blk_cnt  <= '0;
              busy     <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ABSORB: begin
          if (bus.s_valid && s_ready) begin
            m_valid      <= 1'b1;
            m_lane_idx   <= lane_cnt;
            m_block_last <= at_end;
            lane_cnt     <= at_end ? 5'd0 : lane_cnt + 5'd1;
            if (bus.s_last && bus.s_nbytes > 4'd8) begin
              err <= 1'b1;
            end
            if (nb_eff < 4'd8) begin
              m_data     <= tail_lane;
              m_msg_last <= at_end;
              state      <= at_end ? DONE : ZFILL;
            end else begin
              m_data     <= bus.s_data;
              m_msg_last <= 1'b0;
              if (bus.s_last) begin
                state <= PAD;
              end
            end
          end
        end

        PAD: begin
          if (out_free) begin
            m_valid      <= 1'b1;
            m_data       <= {(at_end ? 8'h80 : 8'h00), 48'h0, suffix};
            m_lane_idx   <= lane_cnt;
            m_block_last <= at_end;
            m_msg_last   <= at_end;
            lane_cnt     <= at_end ? 5'd0 : lane_cnt + 5'd1;
            state        <= at_end ? DONE : ZFILL;
          end
        end

        ZFILL: begin
          if (out_free) begin
            m_valid      <= 1'b1;
            m_data       <= at_end ? 64'h8000_0000_0000_0000 : 64'h0;
            m_lane_idx   <= lane_cnt;
            m_block_last <= at_end;
            m_msg_last   <= at_end;
            lane_cnt     <= at_end ? 5'd0 : lane_cnt + 5'd1;
            if (at_end) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          // The final lane is still in the output register; finish once it leaves.
          if (xfer) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha3_pad_unit.sv
// ============================================================================
// Module      : tb_sha3_pad_unit
// Description : Table-driven scoreboard bench for sha3_pad_unit against a byte-level pad10*1 model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sha3_pad_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cmode = 3'd0;
  logic        busy, done, err;
  logic [15:0] blk_cnt;

  logic        start2 = 1'b0;
  logic [2:0]  cmode2 = 3'd0;
  logic        busy2, done2, err2;
  logic [15:0] blk_cnt2;

  sha3_pad_unit_if bus();
  sha3_pad_unit_if bus2();

  sha3_pad_unit #(.CNT_W(16), .SHAKE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .cmode(cmode), .bus(bus),
    .busy(busy), .done(done), .err(err), .blk_cnt(blk_cnt)
  );

  sha3_pad_unit #(.CNT_W(16), .SHAKE_EN(1'b0)) dut_noshake (
    .clk(clk), .rst(rst), .start(start2), .cmode(cmode2), .bus(bus2),
    .busy(busy2), .done(done2), .err(err2), .blk_cnt(blk_cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    int          nfull;
    logic [63:0] full_pat;
    logic [63:0] last_data;
    logic [3:0]  nbytes;
    int          rdy;
    bit          exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  idx;
    logic        bl;
    logic        ml;
  } lane_t;

  int    checks = 0;
  int    passes = 0;
  int    err_cnt = 0;
  int    ready_mode = 0;
  bit    sb_en = 1'b1;
  lane_t sb[$];
  logic [7:0] msg[$];
  logic [7:0] pad[$];
  vec_t  vecs[9];

  bit    stall_prev = 1'b0;
  lane_t held;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int rate_of(input logic [2:0] m);
    case (m)
      3'd0: return 18;
      3'd1: return 17;
      3'd2: return 13;
      3'd3: return 9;
      3'd4: return 21;
      default: return 17;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = ~bus.m_ready;
      default: bus.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (rst || !sb_en) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && bus.m_valid) begin
        chk("stall_hold", bus.m_data == held.data && bus.m_lane_idx == held.idx &&
            bus.m_block_last == held.bl && bus.m_msg_last == held.ml, bus.m_data, held.data);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          chk("lane_extra", 1'b0, bus.m_data, 64'h0);
        end else begin
          lane_t e;
          e = sb.pop_front();
          chk("lane_data", bus.m_data == e.data, bus.m_data, e.data);
          chk("lane_flags", {bus.m_lane_idx, bus.m_block_last, bus.m_msg_last} == {e.idx, e.bl, e.ml},
              64'({bus.m_lane_idx, bus.m_block_last, bus.m_msg_last}), 64'({e.idx, e.bl, e.ml}));
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held = '{bus.m_data, bus.m_lane_idx, bus.m_block_last, bus.m_msg_last};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic start_msg(input logic [2:0] m);
    start = 1'b1;
    cmode = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [3:0] nb, input bit last);
    bit ok = 1'b0;
    bit acc;
    bus.s_valid  = 1'b1;
    bus.s_data   = d;
    bus.s_nbytes = nb;
    bus.s_last   = last;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk); #1;
      if (acc) ok = 1'b1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    if (!ok) chk("beat_timeout", 1'b0, 64'h0, 64'h1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] beats[$];
    logic [63:0] d;
    int nbc, r, rb, plen, nblk;
    lane_t e;
    bit got_done = 1'b0;

    msg.delete();
    beats.delete();
    for (int i = 0; i < v.nfull; i++) begin
      d = (v.full_pat != 64'h0) ? v.full_pat : {$urandom, $urandom};
      beats.push_back(d);
      for (int b = 0; b < 8; b++) msg.push_back(d[8*b +: 8]);
    end
    nbc = (v.nbytes > 4'd8) ? 8 : int'(v.nbytes);
    d = v.last_data;
    for (int b = 0; b < nbc; b++) msg.push_back(d[8*b +: 8]);

    r    = rate_of(v.mode);
    rb   = r * 8;
    plen = (msg.size() / rb + 1) * rb;
    pad.delete();
    for (int i = 0; i < plen; i++) pad.push_back((i < msg.size()) ? msg[i] : 8'h00);
    pad[msg.size()] = pad[msg.size()] | ((v.mode >= 3'd4) ? 8'h1F : 8'h06);
    pad[plen-1]     = pad[plen-1] | 8'h80;
    nblk = plen / rb;
    for (int j = 0; j < plen / 8; j++) begin
      for (int b = 0; b < 8; b++) e.data[8*b +: 8] = pad[8*j + b];
      e.idx = 5'(j % r);
      e.bl  = (j % r) == r - 1;
      e.ml  = (j == plen / 8 - 1);
      sb.push_back(e);
    end

    ready_mode = v.rdy;
    err_cnt = 0;
    start_msg(v.mode);
    @(negedge clk);
    chk("busy_after_start", busy == 1'b1, 64'(busy), 64'h1);
    @(posedge clk); #1;
    foreach (beats[i]) drive_beat(beats[i], 4'($urandom_range(0, 15)), 1'b0);
    drive_beat(v.last_data, v.nbytes, 1'b1);

    for (int c = 0; c < 2000 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    chk("done_pulse", got_done, 64'(got_done), 64'h1);
    chk("busy_at_done", busy == 1'b0, 64'(busy), 64'h0);
    chk("blk_cnt", blk_cnt == 16'(nblk), 64'(blk_cnt), 64'(nblk));
    chk("lanes_left", sb.size() == 0, 64'(sb.size()), 64'h0);
    chk("err_seen", (err_cnt != 0) == v.exp_err, 64'(err_cnt), 64'(v.exp_err));
    sb.delete();
    @(posedge clk); #1;
    chk("done_one_cycle", done == 1'b0, 64'(done), 64'h0);
  endtask

  initial begin
    vecs[0] = '{3'd1, 0,  64'h0, 64'h0,                  4'd0,  0, 1'b0};
    vecs[1] = '{3'd0, 0,  64'h0, 64'h8899_AABB_CCDD_EEFF, 4'd8,  0, 1'b0};
    vecs[2] = '{3'd3, 8,  64'hFFFF_FFFF_FFFF_FFFF, 64'h00FF_FFFF_FFFF_FFFF, 4'd7, 0, 1'b0};
    vecs[3] = '{3'd3, 8,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 0, 1'b0};
    vecs[4] = '{3'd4, 0,  64'h0, 64'hDEAD_BEEF_00AB_CDEF, 4'd3,  1, 1'b0};
    vecs[5] = '{3'd5, 20, 64'h0, 64'hFFEE_DDCC_BBAA_9988, 4'd5,  2, 1'b0};
    vecs[6] = '{3'd2, 12, 64'h0, 64'h0102_0304_0506_0708, 4'd3,  2, 1'b0};
    vecs[7] = '{3'd1, 2,  64'h0, 64'hCAFE_F00D_1234_5678, 4'd12, 0, 1'b1};
    vecs[8] = '{3'd0, 17, 64'h0, 64'h5555_AAAA_5555_AAAA, 4'd8,  1, 1'b0};

    bus.s_valid = 1'b0; bus.s_data = 64'h0; bus.s_nbytes = 4'd0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
    bus2.s_valid = 1'b0; bus2.s_data = 64'h0; bus2.s_nbytes = 4'd0; bus2.s_last = 1'b0; bus2.m_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", bus.m_valid == 1'b0, 64'(bus.m_valid), 64'h0);
    chk("rst_s_ready", bus.s_ready == 1'b0, 64'(bus.s_ready), 64'h0);
    chk("rst_busy", busy == 1'b0, 64'(busy), 64'h0);
    chk("rst_blk_cnt", blk_cnt == 16'h0, 64'(blk_cnt), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Invalid mode 6 on the full-featured unit.
    start_msg(3'd6);
    @(negedge clk);
    chk("mode6_err", err == 1'b1, 64'(err), 64'h1);
    chk("mode6_busy", busy == 1'b0, 64'(busy), 64'h0);
    @(posedge clk); #1;

    // SHAKE modes must be refused when disabled; SHA3 modes still accepted.
    start2 = 1'b1; cmode2 = 3'd4;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(negedge clk);
    chk("noshake_err", err2 == 1'b1, 64'(err2), 64'h1);
    chk("noshake_busy", busy2 == 1'b0, 64'(busy2), 64'h0);
    @(posedge clk); #1;
    start2 = 1'b1; cmode2 = 3'd1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(negedge clk);
    chk("noshake_sha3_busy", busy2 == 1'b1, 64'(busy2), 64'h1);
    chk("noshake_sha3_err", err2 == 1'b0, 64'(err2), 64'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while lane 5 of a mode 1 block sits in the output register.
    sb_en = 1'b0;
    ready_mode = 0;
    start_msg(3'd1);
    for (int i = 0; i < 6; i++) drive_beat({$urandom, $urandom}, 4'd8, 1'b0);
    chk("pre_rst_lane", bus.m_lane_idx == 5'd5 && bus.m_valid, 64'(bus.m_lane_idx), 64'h5);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_flags", {bus.m_valid, bus.s_ready, busy, done, err, bus.m_block_last, bus.m_msg_last} == 7'h0,
        64'({bus.m_valid, bus.s_ready, busy, done, err, bus.m_block_last, bus.m_msg_last}), 64'h0);
    chk("midrst_data", bus.m_data == 64'h0, bus.m_data, 64'h0);
    chk("midrst_idx_cnt", bus.m_lane_idx == 5'd0 && blk_cnt == 16'h0, 64'({bus.m_lane_idx, blk_cnt}), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    sb_en = 1'b1;
    run_vec(vecs[0]);
    run_vec(vecs[6]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/sha3_pad_unit.md
SHA3_PAD_UNIT -- requirements
Module: sha3_pad_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the block counter output.
REQ-002 Parameter SHAKE_EN, default 1: when set to 0, modes 4 and 5 are rejected as invalid.
REQ-003 The clock and reset ports SHALL be: clk  in  1  single clock, all logic on the rising edge; rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that latches cmode and begins a message.
REQ-005 cmode  in  3  mode select: 0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256; 6 and 7 are invalid.
REQ-006 s_valid/s_ready  in/out  1/1  input beat handshake.
REQ-007 s_data  in  64  message lane; byte i = s_data[8i+7:8i] (little-endian).
REQ-008 s_nbytes  in  4  valid bytes (0-8) in the last beat; ignored on non-last beats, which are always 8 bytes.
REQ-009 s_last  in  1  marks the final message beat.
REQ-010 m_valid/m_ready  out/in  1/1  output lane handshake.
REQ-011 m_data  out  64  padded lane; m_lane_idx  out  5  lane index within the block.
REQ-012 m_block_last  out  1  marks the last lane of a rate block; m_msg_last  out  1  marks the last lane of the final block.
REQ-013 busy  out  1; done  out  1 (one-cycle pulse); blk_cnt  out  CNT_W  blocks emitted; err  out  1 (one-cycle pulse).

Function
REQ-014 Rate lanes R SHALL be fixed by the latched cmode: 18, 17, 13, 9, 21, 17 for modes 0-5 respectively.
REQ-015 Suffix byte SHALL be 0x06 for SHA3 modes and 0x1F for SHAKE modes; the final byte of the block is ORed with 0x80 (pad10*1).
REQ-016 FSM states: IDLE, ABSORB, PAD, ZFILL, DONE.
REQ-017 IDLE transitions:
- start with a valid mode -> ABSORB, lane counter=0, blk_cnt=0, busy=1.
- start with an invalid mode (6/7, or 4/5 when SHAKE_EN=0) -> err pulse, remain in IDLE.
REQ-018 start SHALL be ignored outside IDLE; s_ready=0 outside ABSORB.
REQ-019 ABSORB handshake and latency:
- Single output register; s_ready = !m_valid || m_ready.
- Each accepted beat appears on m_data the next cycle (latency 1).
REQ-020 m_data, m_lane_idx and all flags SHALL hold stable while m_valid=1 and m_ready=0.
REQ-021 Lane counter behaviour:
- Increments on each output transfer.
- At R-1 the lane is flagged m_block_last, the counter wraps to 0, and blk_cnt increments, saturating at all-ones.
REQ-022 Last beat with s_nbytes<8:
- Bytes at index >= s_nbytes are zeroed and byte[s_nbytes] = suffix.
- If that lane is R-1, byte7 is also ORed with 0x80 (e.g. nbytes=7 SHA3 gives byte7=0x86), with m_msg_last=1 -> DONE.
- Otherwise -> ZFILL.
REQ-023 Last beat with s_nbytes=8: the lane is emitted unmodified, then -> PAD.
REQ-024 PAD SHALL emit one lane = suffix in byte0 (ORed with 0x80 in byte7 if at lane R-1, giving m_msg_last -> DONE), otherwise -> ZFILL; this applies whether or not the data lane was R-1.
REQ-025 ZFILL SHALL emit zero lanes until lane R-1, which is 0x8000_0000_0000_0000 with m_block_last=m_msg_last=1 -> DONE.
REQ-026 s_nbytes values 9-15 SHALL be treated as 8, with an err pulse.
REQ-027 DONE: on the cycle after the m_msg_last transfer, pulse done=1, busy=0, hold blk_cnt until the next start, -> IDLE.

Reset
REQ-028 rst=1 at any clock edge, including mid-block or under backpressure, SHALL force IDLE.
REQ-029 On reset, m_valid, s_ready, busy, done, err, m_block_last and m_msg_last SHALL be 0; m_data, m_lane_idx, blk_cnt = 0; the partially padded block is discarded.
REQ-030 After rst is released, the first start SHALL be accepted on the next cycle.

Verification
REQ-031 Mode 1, empty message (s_last, nbytes=0) -> 17 lanes: lane0=0x06, lanes 1-15=0, lane16=0x8000_0000_0000_0000 with msg_last; blk_cnt=1; done pulses.
REQ-032 Mode 0, one beat 0x8899AABBCCDDEEFF nbytes=8 last -> lane0=data, lane1=0x06, lanes 2-16=0, lane17=0x80<<56; 18 lanes total.
REQ-033 Mode 3: 8 full beats of all-ones, then a last beat 0x00FF_FFFF_FFFF_FFFF with nbytes=7 -> lane8=0x86FF_FFFF_FFFF_FFFF with block_last and msg_last; blk_cnt=1.
REQ-034 Mode 3, 9 full beats last -> block 1 is the raw data; block 2 has lane0=0x06, lane8=0x80<<56; blk_cnt=2; m_block_last asserted twice.
REQ-035 Mode 4, 3-byte message 0xABCDEF, with m_ready toggling every cycle -> lane0=0x1FABCDEF held stable while stalled; 21 lanes, lane20=0x80<<56; no lane lost or duplicated.
REQ-036 cmode=6 start -> err pulse, busy stays 0; rst asserted at lane 5 of a mode 1 block -> all outputs zero next cycle, and a new message then pads correctly.
